load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// Memory-access stage fed by the effective-address stage of the MIPS32 datapath.
// Takes the computed address, the opcode and the rt value, and runs one load or store on a word-wide data memory over a req/ack handshake.
// Stores are steered into byte lanes with byte enables; load data is extracted and sign- or zero-extended.
// Misaligned accesses and bus timeouts are flagged; neither touches memory beyond the timed-out request.
// PARAMETERS
// TIMEOUT_CYCLES  255  ACCESS-state cycles without mem_ack before bus_error is raised (>=1)
// PORTS
// clk           in   1   rising-edge clock
// reset         in   1   synchronous, active-high
// start         in   1   launch an access; sampled only in IDLE
// opcode        in   6   0x20 lb, 0x21 lh, 0x23 lw, 0x24 lbu, 0x25 lhu, 0x28 sb, 0x29 sh, 0x2b sw
// addr          in   32  effective address (rs + offset)
// store_data    in   32  rt content for stores
// busy          out  1   high in every state except IDLE
// done          out  1   one-cycle completion pulse
// load_result   out  32  extended load data; valid with done, then held
// misaligned    out  1   high with done when the access was misaligned
// bus_error     out  1   high with done when the access timed out
// mem_req       out  1   memory request; held until mem_ack or timeout
// mem_we        out  1   1 = write
// mem_addr      out  32  {addr[31:2],2'b00}
// mem_be        out  4   byte enables; bit k drives bits [8k+7:8k]
// mem_wdata     out  32  lane-replicated store data
// mem_rdata     in   32  read data; valid when mem_ack=1
// mem_ack       in   1   one-cycle acknowledge
// BEHAVIOUR
// - All outputs are registered. Reset drives every output to 0 and the FSM to IDLE.
// - Reset during ACCESS: mem_req is 0 the next cycle and no done pulse is produced.
// - Little-endian lanes: byte at addr[1:0]=k sits in bits [8k+7:8k].
// - FSM states: IDLE, ACCESS, DONE, FAULT.
// - IDLE, start=1, opcode in list:
//   - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): go to FAULT.
//   - Otherwise latch opcode and addr[1:0], drive mem_* and mem_req=1, and go to ACCESS.
// - IDLE, start=1, opcode not in list: ignored; FSM stays in IDLE.
// - start while busy: ignored.
// - ACCESS: mem_req=1 and mem_* held stable. The cycle count starts at 0 on entry.
//   - mem_ack=1 (including the first ACCESS cycle): drop mem_req next cycle. For loads, capture the extended result. Go to DONE.
//   - Count reaches TIMEOUT_CYCLES-1 with no ack: drop mem_req, set bus_error, go to DONE.
// - DONE: done=1 for one cycle (bus_error as set), then IDLE.
// - FAULT: done=1 and misaligned=1 for one cycle, mem_req=0, then IDLE.
// - misaligned and bus_error are low whenever done=0.
// - Latency: start at cycle N, mem_req at N+1, ack at N+1 at earliest, done at N+2. FAULT: done at N+1.
// - mem_be:
//   - sb: 4'b0001<<addr[1:0]
//   - sh: addr[1] ? 4'b1100 : 4'b0011
//   - sw: 4'b1111
//   - loads: mem_be=4'b1111, mem_we=0.
// - mem_wdata:
//   - sb: {4{store_data[7:0]}}
//   - sh: {2{store_data[15:0]}}
//   - sw: store_data
//   - loads: 0
// - Loads select the lane by latched addr[1:0]:
//   - lb/lh sign-extend to 32 bits.
//   - lbu/lhu zero-extend to 32 bits.
//   - lw passes the word through.
// - load_result updates only on a successful load and is held through stores, faults and timeouts.
// - An ack arriving outside ACCESS is ignored.
// TESTING
// - sw addr=0x100, data=0xDEADBEEF, ack on 1st cycle -> mem_addr=0x100, be=1111, wdata=0xDEADBEEF, done 2 cycles after start.
// - sb addr=0x103, data=0x000000A5 -> be=1000, wdata=0xA5A5A5A5; sh addr=0x102, data=0x1234 -> be=1100, wdata=0x12341234.
// - rdata=0x80F07F01: lb @0x203 -> 0xFFFFFF80; lbu @0x203 -> 0x00000080; lh @0x202 -> 0xFFFF80F0; lhu @0x200 -> 0x00007F01.
// - lw addr=0x102 -> no mem_req; done=1 and misaligned=1 one cycle after start; load_result unchanged.
// - TIMEOUT_CYCLES=4, no ack -> mem_req high for 4 cycles, then done=1 and bus_error=1; start while busy ignored.
// - reset on 2nd ACCESS cycle -> mem_req=0 and busy=0 next cycle, no done; a fresh lw then completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// MIPS32 memory-access stage: runs one load or store per start over a req/ack
// data-memory handshake, with byte-lane steering, load extension, misalignment and timeout flags.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_result,
  output logic        misaligned,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_FAULT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        op_q, op_d;
  logic [1:0]        lane_q, lane_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       load_result_q, load_result_d;
  logic              misaligned_q, misaligned_d;
  logic              bus_error_q, bus_error_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  function automatic logic is_valid_op(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) ||
           (op == OP_LHU) || (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
    logic half, word;
    half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    word = (op == OP_LW) || (op == OP_SW);
    return (half && lo[0]) || (word && (lo != 2'b00));
  endfunction

  function automatic logic [3:0] calc_be(input logic [5:0] op, input logic [1:0] lo);
    case (op)
      OP_SB:   return 4'b0001 << lo;
      OP_SH:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] calc_wdata(input logic [5:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   return {4{d[7:0]}};
      OP_SH:   return {2{d[15:0]}};
      OP_SW:   return d;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [5:0] op, input logic [1:0] lo,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{lo, 3'b000} +: 8];
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    lane_d        = lane_q;
    done_d        = 1'b0;
    misaligned_d  = 1'b0;
    bus_error_d   = 1'b0;
    load_result_d = load_result_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start && is_valid_op(opcode)) begin
          if (is_misaligned(opcode, addr[1:0])) begin
            state_d      = S_FAULT;
            done_d       = 1'b1;
            misaligned_d = 1'b1;
          end else begin
            state_d     = S_ACCESS;
            cnt_d       = '0;
            op_d        = opcode;
            lane_d      = addr[1:0];
            mem_req_d   = 1'b1;
            mem_we_d    = is_store(opcode);
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = calc_be(opcode, addr[1:0]);
            mem_wdata_d = calc_wdata(opcode, store_data);
          end
        end
      end
      S_ACCESS: begin
        // An ack on the final counted cycle still wins over the timeout.
        if (mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          if (!is_store(op_q)) load_result_d = extend_load(op_q, lane_q, mem_rdata);
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          mem_req_d   = 1'b0;
          done_d      = 1'b1;
          bus_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      lane_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      load_result_q <= '0;
      misaligned_q  <= 1'b0;
      bus_error_q   <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_be_q      <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      lane_q        <= lane_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      load_result_q <= load_result_d;
      misaligned_q  <= misaligned_d;
      bus_error_q   <= bus_error_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign load_result = load_result_q;
  assign misaligned  = misaligned_q;
  assign bus_error   = bus_error_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single accesses plus hand-written
// timeout, busy-start, invalid-opcode and reset-during-access sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy, done, misaligned, bus_error;
  logic [31:0] load_result;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  int n_cmp = 0;
  int n_fail = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .addr(addr),
    .store_data(store_data), .busy(busy), .done(done), .load_result(load_result),
    .misaligned(misaligned), .bus_error(bus_error), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_lr;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    opcode = v.op; addr = v.addr; store_data = v.sdata; start = 1'b1;
    step();
    start = 1'b0;
    if (v.exp_mis) begin
      check($sformatf("v%0d fault done", i), {31'b0, done}, 32'd1);
      check($sformatf("v%0d fault misaligned", i), {31'b0, misaligned}, 32'd1);
      check($sformatf("v%0d fault mem_req", i), {31'b0, mem_req}, 32'd0);
      check($sformatf("v%0d fault bus_error", i), {31'b0, bus_error}, 32'd0);
      check($sformatf("v%0d fault load_result", i), load_result, v.exp_lr);
    end else begin
      check($sformatf("v%0d mem_req", i), {31'b0, mem_req}, 32'd1);
      check($sformatf("v%0d busy", i), {31'b0, busy}, 32'd1);
      check($sformatf("v%0d done early", i), {31'b0, done}, 32'd0);
      check($sformatf("v%0d mem_addr", i), mem_addr, v.exp_addr);
      check($sformatf("v%0d mem_be", i), {28'b0, mem_be}, {28'b0, v.exp_be});
      check($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, v.exp_we});
      check($sformatf("v%0d mem_wdata", i), mem_wdata, v.exp_wdata);
      mem_ack = 1'b1; mem_rdata = v.rdata;
      step();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      check($sformatf("v%0d done", i), {31'b0, done}, 32'd1);
      check($sformatf("v%0d mem_req dropped", i), {31'b0, mem_req}, 32'd0);
      check($sformatf("v%0d misaligned", i), {31'b0, misaligned}, 32'd0);
      check($sformatf("v%0d bus_error", i), {31'b0, bus_error}, 32'd0);
      check($sformatf("v%0d load_result", i), load_result, v.exp_lr);
    end
    step();
    check($sformatf("v%0d done cleared", i), {31'b0, done}, 32'd0);
    check($sformatf("v%0d misaligned cleared", i), {31'b0, misaligned}, 32'd0);
    check($sformatf("v%0d idle", i), {31'b0, busy}, 32'd0);
  endtask

  initial begin
    //           op     addr          sdata         rdata         mis  exp_addr      be       we    wdata         lr
    vecs[0]  = '{6'h2b, 32'h00000100, 32'hDEADBEEF, 32'h0,        1'b0, 32'h00000100, 4'b1111, 1'b1, 32'hDEADBEEF, 32'h00000000};
    vecs[1]  = '{6'h28, 32'h00000103, 32'h000000A5, 32'h0,        1'b0, 32'h00000100, 4'b1000, 1'b1, 32'hA5A5A5A5, 32'h00000000};
    vecs[2]  = '{6'h29, 32'h00000102, 32'h00001234, 32'h0,        1'b0, 32'h00000100, 4'b1100, 1'b1, 32'h12341234, 32'h00000000};
    vecs[3]  = '{6'h20, 32'h00000203, 32'h0,        32'h80F07F01, 1'b0, 32'h00000200, 4'b1111, 1'b0, 32'h0,        32'hFFFFFF80};
    vecs[4]  = '{6'h24, 32'h00000203, 32'h0,        32'h80F07F01, 1'b0, 32'h00000200, 4'b1111, 1'b0, 32'h0,        32'h00000080};
    vecs[5]  = '{6'h21, 32'h00000202, 32'h0,        32'h80F07F01, 1'b0, 32'h00000200, 4'b1111, 1'b0, 32'h0,        32'hFFFF80F0};
    vecs[6]  = '{6'h25, 32'h00000200, 32'h0,        32'h80F07F01, 1'b0, 32'h00000200, 4'b1111, 1'b0, 32'h0,        32'h00007F01};
    vecs[7]  = '{6'h23, 32'h00000102, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h00007F01};
    vecs[8]  = '{6'h29, 32'h00000101, 32'h0000FFFF, 32'h0,        1'b1, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h00007F01};
    vecs[9]  = '{6'h23, 32'h00000300, 32'h0,        32'h12345678, 1'b0, 32'h00000300, 4'b1111, 1'b0, 32'h0,        32'h12345678};
    vecs[10] = '{6'h28, 32'h00000101, 32'h000000C3, 32'h0,        1'b0, 32'h00000100, 4'b0010, 1'b1, 32'hC3C3C3C3, 32'h12345678};
    vecs[11] = '{6'h20, 32'h00000202, 32'h0,        32'h80F07F01, 1'b0, 32'h00000200, 4'b1111, 1'b0, 32'h0,        32'hFFFFFFF0};
    vecs[12] = '{6'h24, 32'h00000201, 32'h0,        32'h80F07F01, 1'b0, 32'h00000200, 4'b1111, 1'b0, 32'h0,        32'h0000007F};
    vecs[13] = '{6'h29, 32'h00000100, 32'hABCD5678, 32'h0,        1'b0, 32'h00000100, 4'b0011, 1'b1, 32'h56785678, 32'h0000007F};
    vecs[14] = '{6'h21, 32'h00000200, 32'h0,        32'h80F07F01, 1'b0, 32'h00000200, 4'b1111, 1'b0, 32'h0,        32'h00007F01};
    vecs[15] = '{6'h21, 32'h00000203, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h00007F01};

    reset = 1'b1; start = 1'b0; opcode = 6'h0; addr = 32'h0; store_data = 32'h0;
    mem_rdata = 32'h0; mem_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset mem_req", {31'b0, mem_req}, 32'd0);
    check("reset load_result", load_result, 32'h0);
    check("reset mem_be", {28'b0, mem_be}, 32'd0);
    check("reset mem_addr", mem_addr, 32'h0);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Unlisted opcode is ignored.
    opcode = 6'h22; addr = 32'h00000400; start = 1'b1;
    step();
    start = 1'b0;
    check("badop busy", {31'b0, busy}, 32'd0);
    check("badop mem_req", {31'b0, mem_req}, 32'd0);
    check("badop done", {31'b0, done}, 32'd0);

    // Timeout after 4 ACCESS cycles; a start while busy must not disturb the access.
    opcode = 6'h23; addr = 32'h00000400; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("tmo mem_req c%0d", c), {31'b0, mem_req}, 32'd1);
      check($sformatf("tmo done c%0d", c), {31'b0, done}, 32'd0);
      check($sformatf("tmo addr c%0d", c), mem_addr, 32'h00000400);
      check($sformatf("tmo we c%0d", c), {31'b0, mem_we}, 32'd0);
      if (c == 1) begin
        opcode = 6'h2b; addr = 32'h00000500; store_data = 32'h55555555; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    check("tmo done", {31'b0, done}, 32'd1);
    check("tmo bus_error", {31'b0, bus_error}, 32'd1);
    check("tmo misaligned", {31'b0, misaligned}, 32'd0);
    check("tmo mem_req dropped", {31'b0, mem_req}, 32'd0);
    check("tmo load_result held", load_result, 32'h00007F01);
    step();
    check("tmo done cleared", {31'b0, done}, 32'd0);
    check("tmo bus_error cleared", {31'b0, bus_error}, 32'd0);
    check("tmo idle", {31'b0, busy}, 32'd0);

    // Reset on the second ACCESS cycle aborts silently.
    opcode = 6'h23; addr = 32'h00000500; start = 1'b1;
    step();
    start = 1'b0;
    check("rst acc1 mem_req", {31'b0, mem_req}, 32'd1);
    step();
    check("rst acc2 mem_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst mem_req", {31'b0, mem_req}, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step();
    mem_ack = 1'b0;
    check("stray ack done", {31'b0, done}, 32'd0);
    check("stray ack load_result", load_result, 32'h0);

    // Fresh lw with ack on the third ACCESS cycle.
    opcode = 6'h23; addr = 32'h00000600; start = 1'b1;
    step();
    start = 1'b0;
    check("fresh mem_addr", mem_addr, 32'h00000600);
    step();
    check("fresh wait done", {31'b0, done}, 32'd0);
    step();
    check("fresh still req", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    check("fresh done", {31'b0, done}, 32'd1);
    check("fresh bus_error", {31'b0, bus_error}, 32'd0);
    check("fresh load_result", load_result, 32'hCAFEF00D);
    step();
    check("fresh done cleared", {31'b0, done}, 32'd0);
    check("fresh held", load_result, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
